cross_bar_slave_responder: RTL and testbench

//  Slave-side endpoint of the crossbar request/ack/resp protocol: sits on one slave port of

---
 rtl/cross_bar_pkg.sv | 42 ++++
 rtl/slave_mem_sp.sv | 39 +++
 rtl/cross_bar_slave_responder.sv | 166 ++++++++++++++++
 tb/tb_cross_bar_slave_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cross_bar_pkg.sv
// Shared definitions for the crossbar slave responder: bus widths, command
// encoding, responder FSM state codes and the address-error helper.
package cross_bar_pkg;

    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned SLAVE_SEL_MSB = 31;
    localparam int unsigned SLAVE_SEL_LSB = 30;

    // Latency counters cover the full 1..15 range of both latency parameters.
    localparam int unsigned CNT_WIDTH = $clog2(16);

    // Data returned on a read that fails the address check.
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    // Responder FSM state codes.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_ACK  = 3'd1;
    localparam state_t ST_ACK       = 3'd2;
    localparam state_t ST_WAIT_RESP = 3'd3;
    localparam state_t ST_RESP      = 3'd4;

    // True when the address does not belong to this slave: wrong slave select,
    // any bit set between the select field and the word index, or a
    // non-word-aligned byte offset.
    function automatic logic addr_in_error(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [1:0]            slave_id,
                                           input int unsigned           idx_width);
        logic [ADDR_WIDTH-1:0] mid_mask;
        mid_mask = ((32'd1 << SLAVE_SEL_LSB) - 32'd1) & ~((32'd1 << (idx_width + 2)) - 32'd1);
        return (addr[SLAVE_SEL_MSB:SLAVE_SEL_LSB] != slave_id) ||
               ((addr & mid_mask) != '0) ||
               (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/slave_mem_sp.sv
// Single-port RAM, synchronous write and synchronous read. The read register
// only updates when re is high, so it holds the last word read.
module slave_mem_sp
    import cross_bar_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned IDX_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read register keeps its value unless a read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[idx];
        end
    end

    // Storage array and read register; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cross_bar_slave_responder.sv
// Slave-side endpoint of the crossbar req/ack/resp protocol backed by a
// word-addressed RAM. Acks each request ACK_LATENCY cycles after it is sampled
// in IDLE, commits writes on the ack cycle, and returns read data with a resp
// pulse RESP_LATENCY cycles after the ack.
// Optional feature: define CROSS_BAR_SLAVE_ADDR_CHECK_EN to flag requests whose
// address does not decode to this slave (writes dropped, reads return ERR_DATA).
module cross_bar_slave_responder
    import cross_bar_pkg::*;
#(
    parameter logic [1:0]  SLAVE_ID     = 2'd0,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned ACK_LATENCY  = 2,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cmd,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned IDX_WIDTH = $clog2(DEPTH);

    // WAIT_ACK lasts ACK_LATENCY cycles; WAIT_RESP lasts RESP_LATENCY-1 cycles
    // and is skipped entirely when RESP_LATENCY is 1.
    localparam logic [CNT_WIDTH-1:0] ACK_LOAD  = CNT_WIDTH'(ACK_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] RESP_LOAD =
        (RESP_LATENCY > 1) ? CNT_WIDTH'(RESP_LATENCY - 2) : '0;

    if ((ACK_LATENCY < 1) || (ACK_LATENCY > 15)) begin : g_bad_ack_latency
        $error("ACK_LATENCY must be in 1..15");
    end
    if ((RESP_LATENCY < 1) || (RESP_LATENCY > 15)) begin : g_bad_resp_latency
        $error("RESP_LATENCY must be in 1..15");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    state_t                 state_d, state_q;
    logic [CNT_WIDTH-1:0]   cnt_d, cnt_q;
    logic                   err_d, err_q;
    logic [DATA_WIDTH-1:0]  rdata_d, rdata_q;

    logic                   req_err;
    logic                   is_write;
    logic [IDX_WIDTH-1:0]   mem_idx;
    logic                   mem_we;
    logic                   mem_re;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic [DATA_WIDTH-1:0]  resp_data;

    assign is_write = (cmd_e'(cmd) == CMD_WRITE);
    assign mem_idx  = addr[IDX_WIDTH+1:2];

`ifdef CROSS_BAR_SLAVE_ADDR_CHECK_EN
    assign req_err = addr_in_error(addr, SLAVE_ID, IDX_WIDTH);
`else
    // Without the check the word index simply wraps modulo DEPTH.
    assign req_err = 1'b0;
    logic unused_addr_cfg;
    assign unused_addr_cfg = ^{SLAVE_ID, addr[SLAVE_SEL_MSB:IDX_WIDTH+2], addr[1:0]};
`endif

    // Data presented on the resp cycle: the captured word, or the error pattern.
    assign resp_data = err_q ? ERR_DATA : mem_rdata;

    // Next-state logic: FSM, latency counter, error flag, rdata holding register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WAIT_ACK;
                    cnt_d   = ACK_LOAD;
                end
            end
            ST_WAIT_ACK: begin
                if (!req) begin
                    // Requester withdrew: abandon without ack or side effects.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                // addr/cmd/wdata are only looked at in this cycle.
                err_d = req_err;
                if (is_write) begin
                    mem_we  = !req_err && !rst;
                    state_d = ST_IDLE;
                end else begin
                    mem_re = !rst;
                    if (RESP_LATENCY > 1) begin
                        state_d = ST_WAIT_RESP;
                        cnt_d   = RESP_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // Freeze the returned word so rdata holds it until the next resp.
                rdata_d = resp_data;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    slave_mem_sp #(
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (mem_idx),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

    assign ack   = (state_q == ST_ACK);
    assign resp  = (state_q == ST_RESP);
    // rdata switches to the new word in the same cycle resp rises.
    assign rdata = resp ? resp_data : rdata_q;

endmodule

// File: tb/tb_cross_bar_slave_responder.sv
// Scoreboard bench for cross_bar_slave_responder. Drivers compute, from the
// protocol timing rules and a plain array memory model, when ack/resp must
// appear and what data they carry; a monitor pops and compares every cycle.
module tb_cross_bar_slave_responder;

    localparam logic [1:0]  SlaveId = 2'd1;
    localparam int unsigned Depth   = 256;
    localparam int          AckLat  = 2;
    localparam int          RespLat = 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          known;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free_edge = 0;
    bit mon_en = 1'b0;

    exp_t ack_q[$];
    exp_t resp_q[$];
    logic [31:0] exp_rdata = '0;
    bit          exp_rdata_known = 1'b1;

    logic [31:0] mmem   [Depth];
    bit          mknown [Depth];

    cross_bar_slave_responder #(
        .SLAVE_ID     (SlaveId),
        .DEPTH        (Depth),
        .ACK_LATENCY  (AckLat),
        .RESP_LATENCY (RespLat)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .addr  (addr),
        .cmd   (cmd),
        .wdata (wdata),
        .ack   (ack),
        .resp  (resp),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_err(input logic [31:0] a);
`ifdef CROSS_BAR_SLAVE_ADDR_CHECK_EN
        return (a[31:30] != SlaveId) || (a[29:0] >= 30'(Depth * 4)) || (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % Depth);
    endfunction

    function automatic logic [31:0] addr_of(input int w);
        return {SlaveId, 30'(w * 4)};
    endfunction

    function automatic int pool_word(input int k);
        return (k < 10) ? k : 240 + k;
    endfunction

    function automatic logic [31:0] rand_addr();
        int         w;
        logic [1:0] sel;
        logic [1:0] lo;
        w   = pool_word(int'($urandom_range(0, 15)));
        sel = ($urandom_range(0, 9) < 8) ? SlaveId : 2'($urandom);
        if ($urandom_range(0, 9) == 0) w = w + int'(Depth * $urandom_range(1, 3));
        lo  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
        return {sel, 30'(w * 4 + int'(lo))};
    endfunction

    function automatic int earliest_sample();
        return (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    endfunction

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit keep);
        int   s;
        int   idx;
        bit   err;
        exp_t e;
        req = 1'b1; cmd = wr; addr = a; wdata = d;
        s   = earliest_sample();
        err = m_err(a);
        idx = m_idx(a);
        e.cyc = s + AckLat; e.data = '0; e.known = 1'b1;
        ack_q.push_back(e);
        if (wr) begin
            if (!err) begin
                mmem[idx]   = d;
                mknown[idx] = 1'b1;
            end
            free_edge = s + AckLat + 2;
        end else begin
            e.cyc   = s + AckLat + RespLat;
            e.known = err || mknown[idx];
            e.data  = err ? 32'hDEAD_BEEF : mmem[idx];
            resp_q.push_back(e);
            free_edge = s + AckLat + RespLat + 2;
        end
        while (cyc < s + AckLat + 1) @(negedge clk);
        if (!keep) begin
            req = 1'b0;
            @(negedge clk);
        end
    endtask

    // Withdraw req one cycle after it is sampled: no ack, no write.
    task automatic abort_txn(input logic [31:0] a);
        int s;
        req = 1'b1; cmd = 1'b1; addr = a; wdata = $urandom;
        s = earliest_sample();
        while (cyc < s) @(negedge clk);
        req = 1'b0;
        free_edge = s + 2;
        @(negedge clk);
    endtask

    // Write whose ack cycle coincides with reset: ack seen, write must not land.
    task automatic rst_on_ack_write(input logic [31:0] a, input logic [31:0] d);
        int   s;
        exp_t e;
        req = 1'b1; cmd = 1'b1; addr = a; wdata = d;
        s = earliest_sample();
        e.cyc = s + AckLat; e.data = '0; e.known = 1'b1;
        ack_q.push_back(e);
        while (cyc < s + AckLat) @(negedge clk);
        rst = 1'b1;
        exp_rdata = '0;
        exp_rdata_known = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        free_edge = s + AckLat + 2;
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (ack_q.size() != 0 && ack_q[0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL ack_missing: expected at cycle %0d, none by cycle %0d",
                             ack_q[0].cyc, cyc);
                    void'(ack_q.pop_front());
                end
                if (ack === 1'b1) begin
                    checks++;
                    if (ack_q.size() != 0 && ack_q[0].cyc == cyc) begin
                        void'(ack_q.pop_front());
                    end else begin
                        errors++;
                        $display("FAIL ack_unexpected: ack at cycle %0d, next expected %0d",
                                 cyc, (ack_q.size() != 0) ? ack_q[0].cyc : -1);
                    end
                end
                if (resp_q.size() != 0 && resp_q[0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL resp_missing: expected at cycle %0d, none by cycle %0d",
                             resp_q[0].cyc, cyc);
                    void'(resp_q.pop_front());
                end
                if (resp === 1'b1) begin
                    checks++;
                    if (resp_q.size() != 0 && resp_q[0].cyc == cyc) begin
                        e = resp_q.pop_front();
                        if (e.known) chk("resp_rdata", rdata, e.data);
                        exp_rdata       = e.data;
                        exp_rdata_known = e.known;
                    end else begin
                        errors++;
                        $display("FAIL resp_unexpected: resp at cycle %0d, next expected %0d",
                                 cyc, (resp_q.size() != 0) ? resp_q[0].cyc : -1);
                    end
                end else if (exp_rdata_known) begin
                    chk("rdata_hold", rdata, exp_rdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        for (int i = 0; i < int'(Depth); i++) mknown[i] = 1'b0;
        rst = 1'b1; req = 1'b1; cmd = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_ack", {31'd0, ack}, 32'd0);
            chk("reset_resp", {31'd0, resp}, 32'd0);
            chk("reset_rdata", rdata, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_ack", {31'd0, ack}, 32'd0);
        chk("post_reset_resp", {31'd0, resp}, 32'd0);
        chk("post_reset_rdata", rdata, 32'd0);
        mon_en = 1'b1;
        free_edge = cyc + 1;
        @(negedge clk);

        // Give every word the random traffic can touch a known value.
        for (int k = 0; k < 16; k++) txn(1'b1, addr_of(pool_word(k)), $urandom, 1'b0);

        // Write then read word 5.
        txn(1'b1, addr_of(5), 32'hA5A5_0001, 1'b0);
        txn(1'b0, addr_of(5), 32'h0, 1'b0);
        // req held across read resp cycles.
        txn(1'b0, addr_of(5), 32'h0, 1'b1);
        txn(1'b0, addr_of(5), 32'h0, 1'b1);
        txn(1'b0, addr_of(3), 32'h0, 1'b0);
        // Aborted write leaves the target unchanged.
        abort_txn(addr_of(5));
        txn(1'b0, addr_of(5), 32'h0, 1'b0);
        // Index wrap (or address error when the check is enabled).
        txn(1'b1, addr_of(256), 32'h0000_1234, 1'b0);
        txn(1'b0, addr_of(0), 32'h0, 1'b0);
        // Address outside this slave's select.
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        txn(1'b1, 32'h0000_0010, 32'hFFFF_0000, 1'b0);
        txn(1'b0, addr_of(4), 32'h0, 1'b0);
        // Reset landing on a write's ack cycle.
        rst_on_ack_write(addr_of(7), 32'hCAFE_F00D);
        txn(1'b0, addr_of(7), 32'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) abort_txn(rand_addr());
            else if (r < 50) txn(1'b1, rand_addr(), $urandom, $urandom_range(0, 3) == 0);
            else txn(1'b0, rand_addr(), $urandom, $urandom_range(0, 2) == 0);
        end
        req = 1'b0;

        while (cyc < free_edge + 3) @(negedge clk);
        mon_en = 1'b0;
        foreach (ack_q[i]) begin
            checks++; errors++;
            $display("FAIL ack_never_seen: expected at cycle %0d", ack_q[i].cyc);
        end
        foreach (resp_q[i]) begin
            checks++; errors++;
            $display("FAIL resp_never_seen: expected at cycle %0d", resp_q[i].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
